ecpri_ram_ctrl: RTL
===================

Name: ecpri_ram_ctrl

Overview:
- Sequencer/arbiter for the eCPRI single-port synchronous RAM, which has a shared bidirectional data bus and cs/we/oe controls.
- Shares the RAM between two requesters: the RX path (write port) and the TX path (read port).
- Arbitrates round-robin, generates cs/we/oe with the RAM's read timing, and owns the tristate on the RAM data bus.
- Rejects out-of-range addresses without touching the RAM.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DEPTH, 256, number of RAM words; addresses >= DEPTH are illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_req  in  1  RX write request; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ack  out  1  one-cycle pulse: write done (or rejected).
- wr_err  out  1  valid with wr_ack: address out of range, RAM not written.
- rd_req  in  1  TX read request; held with rd_addr until rd_ack.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_ack  out  1  one-cycle pulse: read request consumed.
- rd_valid  out  1  one-cycle pulse, cycle after rd_ack: rd_data/rd_err valid.
- rd_data  out  DATA_WIDTH  read data, held until next rd_valid.
- rd_err  out  1  valid with rd_valid: address out of range; rd_data=0.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in WR state, else high-Z.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, all ack/valid/err=0, ram_cs/we/oe=0, ram_addr=0, rd_data=0, ram_data high-Z, last_gnt=RD (so a write wins the first tie).
- Reset mid-transaction: abort immediately; no ack is issued for the aborted request. The requester re-issues it after reset.
- Output timing: RAM controls and acks are decoded from registered state only. There is no combinational path from any *_req to any output.
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, ERR_WR, ERR_RD.
- IDLE: sample wr_req/rd_req.
  - Only one pending: grant it.
  - Both pending: grant the one not equal to last_gnt.
  - Latch the granted address (and write data) and update last_gnt.
  - Granted addr >= DEPTH: go to ERR_WR or ERR_RD. Otherwise go to WR or RD_ADDR.
- WR (1 cycle): ram_cs=1, ram_we=1, ram_oe=0, ram_data=latched data, wr_ack=1, then IDLE. The RAM writes on this cycle's closing edge. Write latency: request sampled in cycle N, ack in N+1.
- RD_ADDR (1 cycle): ram_cs=1, ram_we=0, ram_oe=0. The RAM registers its output on the closing edge. Then RD_DATA.
- RD_DATA (1 cycle): ram_cs=1, ram_we=0, ram_oe=1, rd_ack=1. Capture ram_data into rd_data on the closing edge. Then IDLE, with rd_valid=1 in the following cycle.
- Read latency: sampled in N, rd_ack in N+2, rd_valid/rd_data in N+3. rd_valid may coincide with the next grant's first cycle.
- ERR_WR / ERR_RD (1 cycle): no ram_cs.
  - ERR_WR: wr_ack=1 and wr_err=1.
  - ERR_RD: rd_ack=1; next cycle rd_valid=1, rd_err=1, rd_data=0.
- Request consumption: the requester may keep *_req high for back-to-back transactions; each ack consumes exactly one request. The req value sampled in the cycle after an ack counts as a new request.
- Starvation bound: with both requesters saturated, grants alternate WR, RD, WR, ... Worst-case wait is one read (3 cycles).
- Bus turnaround: ram_data is released (high-Z) in every state except WR. ram_oe is never 1 in the same cycle as ram_we. The controller never drives the bus while the RAM does.
- Address arithmetic: range check is an unsigned compare against DEPTH at ADDR_WIDTH+1 bits. When ADDR_WIDTH is large enough, DEPTH = 2**ADDR_WIDTH is legal.

Decomposition:
- Shared package ecpri_ram_pkg holds:
  - state enum (IDLE, WR, RD_ADDR, RD_DATA, ERR_WR, ERR_RD);
  - grant encoding (GNT_WR, GNT_RD);
  - default width/depth constants shared with ecpri_ram.
- One natural sub-module: ecpri_rr_arb2. It is a two-input round-robin picker: inputs are req[1:0] and last_gnt; outputs are a one-hot gnt and the new last_gnt. The FSM, tristate and datapath stay in ecpri_ram_ctrl.

Test Plan:
- Single write then read: wr addr 0x05 data 0xA5 -> wr_ack 1 cycle after sample, ram_cs=ram_we=1 that cycle. Then rd addr 0x05 -> rd_ack at N+2, rd_valid at N+3 with rd_data=0xA5.
- Simultaneous requests from reset: wr(0x10,0x3C) and rd(0x10) both high -> write granted first. The read then returns 0x3C, proving write-before-read ordering.
- Saturated requesters: both req held high for 20 cycles, write addresses 0..n -> grants strictly alternate WR/RD. No request waits more than 3 cycles. Every write is acked exactly once.
- Out of range: wr addr 256 -> wr_ack+wr_err with ram_cs=0. rd addr 0x0100 -> rd_valid+rd_err with rd_data=0x00. A RAM shadow-model check shows memory unchanged.
- Bus contention: monitor ram_data every cycle over a mixed random sequence -> no X/contention. The controller drives only when ram_we=1. ram_oe & ram_we is never 1.
- Reset mid-read: assert rst_n=0 during RD_ADDR -> all outputs return to reset values asynchronously, no rd_ack/rd_valid. After release, the same request completes with correct data.

Source files
------------

// File: rtl/ecpri_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_ram_pkg
//  Description : Shared types and default geometry for the eCPRI RAM
//                sequencer: FSM state encoding, grant encoding, and the
//                request bit positions used by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecpri_ram_pkg;

  // Default geometry of the eCPRI single-port RAM
  localparam int RAM_ADDR_WIDTH = 16;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_DEPTH      = 256;

  // Bit positions inside the two-bit request / grant vectors
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_ERR_WR  = 3'd4,
    ST_ERR_RD  = 3'd5
  } state_e;

  // Identity of the most recently granted requester
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

endpackage : ecpri_ram_pkg
`default_nettype wire

// File: rtl/ecpri_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_ram_ctrl_if
//  Description : Requester-side handshake bundle of the RAM sequencer:
//                RX write port and TX read port. The requesters use the
//                master modport, the controller uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ecpri_ram_ctrl_if
  import ecpri_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

  // RX write port
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  wr_err;

  // TX read port
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, wr_err, rd_ack, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, wr_err, rd_ack, rd_valid, rd_data, rd_err
  );

endinterface : ecpri_ram_ctrl_if
`default_nettype wire

// File: rtl/ecpri_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_rr_arb2
//  Description : Two-input round-robin picker. A lone request is granted
//                directly; on a tie the requester that was NOT granted last
//                wins. Purely combinational; the caller registers last_gnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecpri_rr_arb2
  import ecpri_ram_pkg::*;
(
  input  logic [1:0] i_req,
  input  gnt_e       i_last_gnt,
  output logic [1:0] o_gnt,
  output gnt_e       o_last_gnt
);

  // Pick the write side unless only the read side asks or the read side is owed the tie
  always_comb begin
    o_gnt      = 2'b00;
    o_last_gnt = i_last_gnt;
    if (i_req[REQ_WR] && (!i_req[REQ_RD] || (i_last_gnt == GNT_RD))) begin
      o_gnt[REQ_WR] = 1'b1;
      o_last_gnt    = GNT_WR;
    end else if (i_req[REQ_RD]) begin
      o_gnt[REQ_RD] = 1'b1;
      o_last_gnt    = GNT_RD;
    end
  end

endmodule : ecpri_rr_arb2
`default_nettype wire

// File: rtl/ecpri_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_ram_ctrl
//  Description : Sequencer/arbiter for the eCPRI single-port synchronous RAM.
//                Shares the RAM between the RX write port and the TX read
//                port, generates cs/we/oe with the RAM's one-cycle read
//                latency, owns the tristate on the data bus, and rejects
//                out-of-range addresses without touching the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecpri_ram_ctrl
  import ecpri_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH      = RAM_DEPTH
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ecpri_ram_ctrl_if.slave       req_if,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  // Range check is done one bit wider so DEPTH == 2**ADDR_WIDTH stays legal
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                r_state;
  gnt_e                  r_last_gnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_wr_ack;
  logic                  r_wr_err;
  logic                  r_rd_ack;
  logic                  r_rd_valid;
  logic                  r_rd_err;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  gnt_e                  w_last_gnt_nxt;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  assign w_req   = {req_if.rd_req, req_if.wr_req};
  assign w_wr_ok = ({1'b0, req_if.wr_addr} < C_DEPTH);
  assign w_rd_ok = ({1'b0, req_if.rd_addr} < C_DEPTH);

  ecpri_rr_arb2 u_arb (
    .i_req      (w_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt),
    .o_last_gnt (w_last_gnt_nxt)
  );

  // Sequencer FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= GNT_RD;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_last_gnt <= w_last_gnt_nxt;
          if (w_gnt[REQ_WR]) begin
            r_wdata  <= req_if.wr_data;
            r_wr_ack <= 1'b1;
            if (w_wr_ok) begin
              r_addr  <= req_if.wr_addr;
              r_cs    <= 1'b1;
              r_we    <= 1'b1;
              r_state <= ST_WR;
            end else begin
              r_wr_err <= 1'b1;
              r_state  <= ST_ERR_WR;
            end
          end else if (w_gnt[REQ_RD]) begin
            if (w_rd_ok) begin
              r_addr  <= req_if.rd_addr;
              r_cs    <= 1'b1;
              r_state <= ST_RD_ADDR;
            end else begin
              r_rd_ack <= 1'b1;
              r_state  <= ST_ERR_RD;
            end
          end
        end
        // The RAM captures the write on the edge that leaves these states
        ST_WR, ST_ERR_WR: begin
          r_state <= ST_IDLE;
        end
        // RAM has registered its output; open the output buffer next cycle
        ST_RD_ADDR: begin
          r_cs     <= 1'b1;
          r_oe     <= 1'b1;
          r_rd_ack <= 1'b1;
          r_state  <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          r_rd_data  <= ram_data;
          r_rd_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_ERR_RD: begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b1;
          r_rd_err   <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus is driven only while the write strobe is up; r_we and r_oe are never set together
  assign ram_data = r_we ? r_wdata : {DATA_WIDTH{1'bz}};

  assign ram_addr        = r_addr;
  assign ram_cs          = r_cs;
  assign ram_we          = r_we;
  assign ram_oe          = r_oe;
  assign req_if.wr_ack   = r_wr_ack;
  assign req_if.wr_err   = r_wr_err;
  assign req_if.rd_ack   = r_rd_ack;
  assign req_if.rd_valid = r_rd_valid;
  assign req_if.rd_data  = r_rd_data;
  assign req_if.rd_err   = r_rd_err;

endmodule : ecpri_ram_ctrl
`default_nettype wire
